// File: rtl/bar_frame_ctrl.sv
// Frame-synchronous bar controller: synchronises the four buttons, queues one command,
// and applies it to the selected-bar index or to that bar's height only during vertical blanking.
module bar_frame_ctrl #(
  parameter int NUM_BARS = 3,
  parameter int H_W      = 10,
  parameter int H_MAX    = 600,
  parameter int H_INIT   = 100,
  parameter int STEP     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    incr,
  input  logic                    decr,
  input  logic                    mv_up,
  input  logic                    mv_down,
  input  logic                    vblank,
  output logic [1:0]              sel,
  output logic [NUM_BARS*H_W-1:0] height,
  output logic                    busy,
  output logic                    upd,
  output logic [7:0]              drop_cnt
);

  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;
  typedef enum logic [1:0] {C_UP, C_DOWN, C_INCR, C_DECR} cmd_t;

  localparam logic [1:0]     LAST   = 2'(NUM_BARS - 1);
  localparam logic [H_W:0]   STEP_X = (H_W+1)'(STEP);
  localparam logic [H_W:0]   MAX_X  = (H_W+1)'(H_MAX);
  localparam logic [H_W-1:0] STEP_V = H_W'(STEP);
  localparam logic [H_W-1:0] MAX_V  = H_W'(H_MAX);
  localparam logic [H_W-1:0] INIT_V = H_W'(H_INIT);

  state_t     state, state_next;
  cmd_t       cmd, cmd_next;
  logic [3:0] btn, s1, s2, prev, rise;
  logic       multi, capture, apply, drop;

  // Button bits ordered by priority: bit 3 wins.
  assign btn   = {mv_up, mv_down, incr, decr};
  assign rise  = s2 & ~prev;
  assign multi = |(rise & (rise - 4'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
    end
  end

  always_comb begin
    if (rise[3])      cmd_next = C_UP;
    else if (rise[2]) cmd_next = C_DOWN;
    else if (rise[1]) cmd_next = C_INCR;
    else              cmd_next = C_DECR;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    apply      = 1'b0;
    drop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (|rise) begin
          capture    = 1'b1;
          drop       = multi;
          state_next = PEND;
        end
      end
      PEND: begin
        drop = |rise;
        if (vblank) begin
          apply      = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        drop = |rise;
        if (!vblank) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // busy is registered from the next state so it lines up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd      <= C_UP;
      sel      <= '0;
      upd      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      upd <= apply;
      if (capture) cmd <= cmd_next;
      if (apply) begin
        case (cmd)
          C_UP:   sel <= (sel == LAST) ? 2'd0 : sel + 2'd1;
          C_DOWN: sel <= (sel == 2'd0) ? LAST : sel - 2'd1;
          default: ;
        endcase
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // The sum is one bit wider than a height so a clamp to H_MAX never sees a wrapped value.
  for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
    logic [H_W-1:0] h, inc_v, dec_v;
    logic [H_W:0]   sum;

    assign sum   = {1'b0, h} + STEP_X;
    assign inc_v = (sum > MAX_X) ? MAX_V : sum[H_W-1:0];
    assign dec_v = (h < STEP_V) ? '0 : h - STEP_V;
    assign height[g*H_W +: H_W] = h;

    always_ff @(posedge clk) begin
      if (rst) begin
        h <= INIT_V;
      end else if (apply && sel == 2'(g)) begin
        if (cmd == C_INCR)      h <= inc_v;
        else if (cmd == C_DECR) h <= dec_v;
      end
    end
  end

endmodule

// File: tb/tb_bar_frame_ctrl.sv
// Self-checking bench for bar_frame_ctrl: directed scenarios plus random frames,
// every cycle compared against a transaction-level reference model.
module tb_bar_frame_ctrl;

  localparam int NB    = 3;
  localparam int HW    = 10;
  localparam int HMAX  = 600;
  localparam int HINIT = 100;
  localparam int STEP  = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            incr = 1'b0, decr = 1'b0, mv_up = 1'b0, mv_down = 1'b0;
  logic            vblank = 1'b0;
  logic [1:0]      sel;
  logic [NB*HW-1:0] height;
  logic            busy, upd;
  logic [7:0]      drop_cnt;

  int checks = 0;
  int passed = 0;

  bar_frame_ctrl #(.NUM_BARS(NB), .H_W(HW), .H_MAX(HMAX), .H_INIT(HINIT), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .incr(incr), .decr(decr), .mv_up(mv_up), .mv_down(mv_down),
    .vblank(vblank), .sel(sel), .height(height), .busy(busy), .upd(upd), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a delay line of sampled buttons, a pending/holding command, plain arithmetic effects.
  int         m_sel, m_drop, m_cmd;
  int         m_h[NB];
  bit         m_pend, m_hold, m_upd;
  logic [3:0] hist[$] = '{4'b0, 4'b0, 4'b0};
  logic [3:0] m_b, m_r;

  task automatic bumpDrop();
    if (m_drop < 255) m_drop++;
  endtask

  always @(posedge clk) begin
    m_b = {mv_up, mv_down, incr, decr};
    if (rst) begin
      m_sel = 0; m_drop = 0; m_cmd = 0;
      m_pend = 0; m_hold = 0; m_upd = 0;
      for (int i = 0; i < NB; i++) m_h[i] = HINIT;
      hist = '{4'b0, 4'b0, 4'b0};
    end else begin
      m_r   = hist[1] & ~hist[2];
      m_upd = 0;
      if (!m_pend && !m_hold) begin
        if (m_r != 0) begin
          for (int i = 3; i >= 0; i--) if (m_r[i]) begin m_cmd = i; break; end
          m_pend = 1;
          if ($countones(m_r) > 1) bumpDrop();
        end
      end else begin
        if (m_r != 0) bumpDrop();
        if (m_pend && vblank) begin
          case (m_cmd)
            3: m_sel = (m_sel + 1) % NB;
            2: m_sel = (m_sel + NB - 1) % NB;
            1: m_h[m_sel] = (m_h[m_sel] + STEP > HMAX) ? HMAX : m_h[m_sel] + STEP;
            default: m_h[m_sel] = (m_h[m_sel] - STEP < 0) ? 0 : m_h[m_sel] - STEP;
          endcase
          m_upd = 1; m_pend = 0; m_hold = 1;
        end else if (m_hold && !vblank) begin
          m_hold = 0;
        end
      end
      hist.push_front(m_b);
      void'(hist.pop_back());
    end
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic compareAll();
    checkOutput("sel", int'(sel), m_sel);
    for (int i = 0; i < NB; i++) checkOutput($sformatf("height%0d", i), int'(height[i*HW +: HW]), m_h[i]);
    checkOutput("busy", int'(busy), int'(m_pend || m_hold));
    checkOutput("upd", int'(upd), int'(m_upd));
    checkOutput("drop_cnt", int'(drop_cnt), m_drop);
  endtask

  // One cycle: compare outputs away from the edge, then drive the next inputs.
  task automatic applyStimulus(input logic [3:0] b, input logic vb, input logic r);
    @(negedge clk);
    compareAll();
    {mv_up, mv_down, incr, decr} = b;
    vblank = vb;
    rst    = r;
  endtask

  task automatic idle(input int n, input logic vb);
    for (int i = 0; i < n; i++) applyStimulus(4'b0, vb, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(4'b0, 1'b0, 1'b1);
    applyStimulus(4'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
  endtask

  // Press during active video, then let one blanking interval go by.
  task automatic pressFrame(input logic [3:0] b);
    applyStimulus(b, 1'b0, 1'b0);
    idle(7, 1'b0);
    idle(6, 1'b1);
    idle(3, 1'b0);
  endtask

  function automatic int hOf(input int i);
    return int'(height[i*HW +: HW]);
  endfunction

  initial begin
    doReset();
    idle(2, 1'b0);
    checkOutput("rst_sel", int'(sel), 0);
    checkOutput("rst_h0", hOf(0), HINIT);
    checkOutput("rst_h2", hOf(2), HINIT);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_drop", int'(drop_cnt), 0);

    applyStimulus(4'b0010, 1'b1, 1'b0);
    idle(6, 1'b1);
    checkOutput("vb_incr_h0", hOf(0), 132);
    checkOutput("vb_incr_h1", hOf(1), 100);
    idle(3, 1'b0);

    doReset();
    pressFrame(4'b0100); checkOutput("mvdown_sel", int'(sel), 2);
    pressFrame(4'b1000); checkOutput("mvup_sel0", int'(sel), 0);
    pressFrame(4'b1000); checkOutput("mvup_sel1", int'(sel), 1);

    doReset();
    pressFrame(4'b0001); checkOutput("decr1", hOf(0), 68);
    pressFrame(4'b0001); checkOutput("decr2", hOf(0), 36);
    pressFrame(4'b0001); checkOutput("decr3", hOf(0), 4);
    pressFrame(4'b0001); checkOutput("decr4", hOf(0), 0);
    for (int i = 0; i < 20; i++) pressFrame(4'b0010);
    checkOutput("incr_sat", hOf(0), HMAX);

    doReset();
    applyStimulus(4'b0010, 1'b0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    idle(5, 1'b0);
    idle(6, 1'b1);
    idle(3, 1'b0);
    checkOutput("drop_h0", hOf(0), 132);
    checkOutput("drop_sel", int'(sel), 0);
    checkOutput("drop_cnt1", int'(drop_cnt), 1);
    pressFrame(4'b1010);
    checkOutput("both_sel", int'(sel), 1);
    checkOutput("both_h0", hOf(0), 132);
    checkOutput("drop_cnt2", int'(drop_cnt), 2);

    doReset();
    applyStimulus(4'b0010, 1'b0, 1'b0);
    idle(4, 1'b0);
    checkOutput("pend_busy", int'(busy), 1);
    applyStimulus(4'b0, 1'b0, 1'b1);
    idle(6, 1'b1);
    checkOutput("rstpend_busy", int'(busy), 0);
    checkOutput("rstpend_h0", hOf(0), HINIT);
    idle(2, 1'b0);

    // Keep the command parked and keep toggling a button to drive drop_cnt into saturation.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'b0001, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b0);
    end
    idle(4, 1'b0);
    checkOutput("drop_sat", int'(drop_cnt), 255);

    doReset();
    for (int f = 0; f < 200; f++) begin
      for (int c = 0; c < 20; c++) begin
        applyStimulus(($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0,
                      (c >= 15) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0);
      end
    end
    idle(3, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bar_frame_ctrl.md
# bar_frame_ctrl

Frame-synchronous controller for the VGA bar renderer: it owns the selected-bar index and the height of every bar. It sits between the four user push-buttons and the pixel datapath. Button presses are synchronised, edge-detected and queued as one pending command. That command is applied only during vertical blanking, so the renderer never shows a height or selection change mid-frame.

## Interface
Parameters:
- NUM_BARS, 3, number of bars (2..4)
- H_W, 10, height width in bits
- H_MAX, 600, maximum bar height in lines (visible area)
- H_INIT, 100, height of every bar after reset
- STEP, 32, height change per incr/decr command

Ports:
- clk  in  1  system clock (pixel clock is clk/2, generated elsewhere)
- rst  in  1  reset, synchronous, active-high
- incr  in  1  raw button, increase selected bar height
- decr  in  1  raw button, decrease selected bar height
- mv_up  in  1  raw button, select next bar
- mv_down  in  1  raw button, select previous bar
- vblank  in  1  high while the timing generator's line count is at or above 600; clk-domain level
- sel  out  2  index of the selected bar
- height  out  NUM_BARS*H_W  packed heights, bar i at [i*H_W +: H_W]
- busy  out  1  a command is pending or being held
- upd  out  1  one-cycle pulse when a command is applied
- drop_cnt  out  8  count of discarded commands, saturating at 255

## Operation
- Each button passes through a 2-FF synchroniser (s1, s2), then a previous-value register. The rise signal is s2 & ~prev.
- Command capture in IDLE:
  - Applies to any rise in the cycle.
  - Simultaneous rises resolve by priority: mv_up > mv_down > incr > decr.
  - Losing simultaneous rises increment drop_cnt once per cycle.
- FSM states:
  - IDLE: busy=0. Any rise latches cmd and moves to PEND.
  - PEND: busy=1. When vblank=1 at the clock edge, apply cmd at that edge, pulse upd, move to HOLD.
  - HOLD: busy=1. Stay while vblank=1. When vblank=0, return to IDLE.
  - This limits the design to at most one applied command per frame.
- Any rise while in PEND or HOLD is discarded and increments drop_cnt. Increment once per cycle regardless of how many buttons rose; saturate at 255.
- Command effects:
  - mv_up: sel = (sel==NUM_BARS-1) ? 0 : sel+1.
  - mv_down: sel = (sel==0) ? NUM_BARS-1 : sel-1.
  - incr: height[sel] = min(height[sel]+STEP, H_MAX). Compute the sum at H_W+1 bits so it never wraps.
  - decr: height[sel] = (height[sel] < STEP) ? 0 : height[sel]-STEP.
- Only the selected bar's height changes; all other heights hold.

## Timing
- Reset values: sel=0, every height=H_INIT, busy=0, upd=0, drop_cnt=0. Reset also clears the FSM to IDLE and clears all synchroniser and prev registers.
- A reset asserted in PEND or HOLD discards the pending command with no update.
- Latency: a button high before edge E0 gives rise during the cycle after E1, and cmd is captured at E2 (state PEND, busy=1 after E2).
  - If vblank=1 at E3: new sel/height are visible and upd=1 after E3, for one cycle.
  - If vblank=0 at E3: the command waits in PEND until the first edge with vblank=1.
- A command captured while vblank is already high in the same frame is still applied in that frame, provided the FSM is in PEND while vblank=1.
- A held button produces exactly one rise; a new rise needs a release of at least one cycle.
- All outputs are registered. sel and height change only on edges where upd goes high.

## Test plan
- Reset, then hold vblank=0 -> sel=0, all heights=100, busy=0, upd=0, drop_cnt=0.
- vblank=1 constant, pulse incr one cycle -> 3 edges later height[0]=132, upd pulses once, other heights stay 100.
- Press mv_down from sel=0, then mv_up twice, each in a separate vblank period -> sel goes 2, then 0, then 1.
- Press decr 4 times on bar 0 (one per frame) -> heights 68, 36, 4, 0. Press incr 20 times -> height saturates at 600.
- vblank=0, press incr then mv_up in separate cycles before vblank -> only incr is applied at vblank, drop_cnt=1. Press both in the same cycle -> mv_up wins, drop_cnt increments.
- Assert rst while in PEND, then vblank=1 -> no upd, heights stay at H_INIT, busy=0.
